// File: rtl/taxi_pkg.sv
// taxi_pkg: state encodings and default constants shared by the
// taxi meter trip sequencer, its interface and testbench.
package taxi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_WAIT = 2'b10,
      ST_END  = 2'b11
   } state_e;

   localparam int CLK_FREQ_HZ  = 50_000_000;
   localparam int WAIT_SEC_DEF = 60;
   localparam int WMIN_W       = 8;

   localparam logic [WMIN_W-1:0] WMIN_MAX = '1;

   function automatic logic [WMIN_W-1:0] sat_inc(
      input logic [WMIN_W-1:0] v
   );
      return (v == WMIN_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/trip_ctrl_if.sv
// trip_ctrl_if: key/wheel inputs and meter control outputs of the
// trip sequencer. master = key/sensor side, slave = trip_ctrl.
interface trip_ctrl_if;
   import taxi_pkg::*;

   logic              start_key;
   logic              end_key;
   logic              pulse_port;
   logic              wheel_tick;
   logic              meter_clr;
   logic              dist_en;
   logic              wait_tick;
   logic [WMIN_W-1:0] wait_min;
   logic              fare_hold;
   logic              seg_en;
   logic              stat_led;
   logic [1:0]        state;

   modport master (
      output start_key, end_key, pulse_port,
      input  wheel_tick, meter_clr, dist_en,
      input  wait_tick, wait_min, fare_hold,
      input  seg_en, stat_led, state
   );

   modport slave (
      input  start_key, end_key, pulse_port,
      output wheel_tick, meter_clr, dist_en,
      output wait_tick, wait_min, fare_hold,
      output seg_en, stat_led, state
   );

endinterface

// File: rtl/pulse_sync_edge.sv
// pulse_sync_edge: 2-flop synchronizer plus registered rising-edge
// strobe. Ports: clk_i, rst_ni (async low), async_i in; edge_o out.
module pulse_sync_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic edge_o
);

   logic s1_q;
   logic s2_q;
   logic prev_q;
   logic edge_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         s1_q   <= async_i;
         s2_q   <= s1_q;
         prev_q <= s2_q;
         edge_q <= s2_q & ~prev_q;
      end
   end

   assign edge_o = edge_q;

endmodule

// File: rtl/trip_ctrl.sv
// trip_ctrl: taxi meter trip sequencer (IDLE/RUN/WAIT/END).
// Ports: sys_clk, sys_rst_n (async low); bus (trip_ctrl_if.slave):
//   start_key, end_key, pulse_port in; wheel_tick, meter_clr,
//   dist_en, wait_tick, wait_min, fare_hold, seg_en, stat_led,
//   state out, all registered.
module trip_ctrl
   import taxi_pkg::*;
#(
   parameter int STOP_TIMEOUT = CLK_FREQ_HZ - 1,
   parameter int CNT_1S       = CLK_FREQ_HZ - 1,
   parameter int WAIT_SEC     = WAIT_SEC_DEF
) (
   input logic        sys_clk,
   input logic        sys_rst_n,
   trip_ctrl_if.slave bus
);

   localparam int IW = $clog2(STOP_TIMEOUT + 1);
   localparam int CW = $clog2(CNT_1S + 1);
   localparam int SW = $clog2(WAIT_SEC + 1);

   localparam logic [IW-1:0] IDLE_TC = IW'(STOP_TIMEOUT);
   localparam logic [CW-1:0] CYC_TC  = CW'(CNT_1S);
   localparam logic [SW-1:0] SEC_TC  = SW'(WAIT_SEC - 1);

   state_e            state_q, state_d;
   logic [IW-1:0]     idle_q, idle_d;
   logic [CW-1:0]     cyc_q, cyc_d;
   logic [SW-1:0]     sec_q, sec_d;
   logic [WMIN_W-1:0] wmin_q, wmin_d;
   logic              wtick_d, clr_d;
   logic              wedge;

   logic wheel_q, clr_q, dist_q, wtick_q;
   logic hold_q, seg_q, led_q;

   pulse_sync_edge u_wheel (
      .clk_i   (sys_clk),
      .rst_ni  (sys_rst_n),
      .async_i (bus.pulse_port),
      .edge_o  (wedge)
   );

   always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      cyc_d   = cyc_q;
      sec_d   = sec_q;
      wmin_d  = wmin_q;
      wtick_d = 1'b0;
      clr_d   = 1'b0;

      // every WAIT cycle is billed, the exit cycle included
      if (state_q == ST_WAIT) begin
         if (cyc_q == CYC_TC) begin
            cyc_d = '0;
            if (sec_q == SEC_TC) begin
               sec_d   = '0;
               wtick_d = 1'b1;
               wmin_d  = sat_inc(wmin_q);
            end else begin
               sec_d = sec_q + 1'b1;
            end
         end else begin
            cyc_d = cyc_q + 1'b1;
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start_key) begin
               state_d = ST_RUN;
               clr_d   = 1'b1;
            end
         end
         ST_RUN: begin
            if (bus.end_key) begin
               state_d = ST_END;
            end else if (wedge) begin
               idle_d = '0;
            end else if (idle_q == IDLE_TC) begin
               state_d = ST_WAIT;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
         ST_WAIT: begin
            if (bus.end_key) begin
               state_d = ST_END;
            end else if (wedge) begin
               state_d = ST_RUN;
               idle_d  = '0;
            end
         end
         ST_END: begin
            if (bus.end_key) begin
               state_d = ST_IDLE;
            end else if (bus.start_key) begin
               state_d = ST_RUN;
               clr_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // new trip: waiting time restarts from zero
      if (clr_d) begin
         idle_d = '0;
         cyc_d  = '0;
         sec_d  = '0;
         wmin_d = '0;
      end
   end

   // outputs are decoded from the next state so they line up
   // with the state register in the same cycle
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         idle_q  <= '0;
         cyc_q   <= '0;
         sec_q   <= '0;
         wmin_q  <= '0;
         wheel_q <= 1'b0;
         clr_q   <= 1'b0;
         dist_q  <= 1'b0;
         wtick_q <= 1'b0;
         hold_q  <= 1'b0;
         seg_q   <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idle_q  <= idle_d;
         cyc_q   <= cyc_d;
         sec_q   <= sec_d;
         wmin_q  <= wmin_d;
         wheel_q <= wedge & ((state_d == ST_RUN) |
                             (state_d == ST_WAIT));
         clr_q   <= clr_d;
         dist_q  <= (state_d == ST_RUN);
         wtick_q <= wtick_d;
         hold_q  <= (state_d == ST_END);
         seg_q   <= (state_d != ST_IDLE);
         led_q   <= (state_d == ST_WAIT);
      end
   end

   assign bus.wheel_tick = wheel_q;
   assign bus.meter_clr  = clr_q;
   assign bus.dist_en    = dist_q;
   assign bus.wait_tick  = wtick_q;
   assign bus.wait_min   = wmin_q;
   assign bus.fare_hold  = hold_q;
   assign bus.seg_en     = seg_q;
   assign bus.stat_led   = led_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_trip_ctrl.sv
// tb_trip_ctrl: directed bench for trip_ctrl with a cycle model
// checked every falling edge plus hand-computed literal checks.
module tb_trip_ctrl;

   localparam int STOP = 99;
   localparam int C1S  = 49;
   localparam int WS   = 3;
   localparam int PER  = (C1S + 1) * WS;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   trip_ctrl_if bus ();

   trip_ctrl #(
      .STOP_TIMEOUT (STOP),
      .CNT_1S       (C1S),
      .WAIT_SEC     (WS)
   ) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // {state, wheel_tick, meter_clr, dist_en, wait_tick,
   //  wait_min, fare_hold, seg_en, stat_led}
   logic [16:0] act_v;
   logic [16:0] exp_v = '0;

   assign act_v = {bus.state, bus.wheel_tick, bus.meter_clr,
                   bus.dist_en, bus.wait_tick, bus.wait_min,
                   bus.fare_hold, bus.seg_en, bus.stat_led};

   // model: 0 idle, 1 run, 2 wait, 3 end
   int m_st = 0;
   int m_w  = 0;
   int m_rf = 0;
   int m_n  = 0;
   bit h1 = 0, h2 = 0, h3 = 0, h4 = 0;

   initial forever begin
      int ns;
      bit wedge, tick, clr;
      logic [7:0] wm;
      logic [1:0] nsv;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_st = 0; m_w = 0; m_rf = 0;
         h1 = 0; h2 = 0; h3 = 0; h4 = 0;
         exp_v = '0;
      end else begin
         m_n++;
         // pulse first sampled 3 edges ago and low the edge before
         wedge = h3 & ~h4;
         h4 = h3; h3 = h2; h2 = h1; h1 = bus.pulse_port;
         ns = m_st; tick = 0; clr = 0;
         if (m_st == 2) begin
            m_w++;
            tick = ((m_w % PER) == 0);
         end
         case (m_st)
            0: if (bus.start_key) begin ns = 1; clr = 1; end
            1: begin
               if (bus.end_key) ns = 3;
               else if (wedge) m_rf = m_n;
               else if (m_n - m_rf == STOP + 1) ns = 2;
            end
            2: begin
               if (bus.end_key) ns = 3;
               else if (wedge) begin ns = 1; m_rf = m_n; end
            end
            default: begin
               if (bus.end_key) ns = 0;
               else if (bus.start_key) begin ns = 1; clr = 1; end
            end
         endcase
         if (clr) begin m_w = 0; m_rf = m_n; end
         m_st = ns;
         wm = (m_w / PER > 255) ? 8'd255 : 8'(m_w / PER);
         nsv = 2'(ns);
         exp_v = {nsv, wedge & (ns == 1 || ns == 2), clr,
                  ns == 1, tick, wm, ns == 3, ns != 0, ns == 2};
      end
   end

   initial forever begin
      @(negedge clk);
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         if (errors < 40)
            $display("FAIL cycle_outputs t=%0t got=%h want=%h",
                     $time, act_v, exp_v);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   int ncyc = 0;
   int ticks = 0;
   int last_tick = 0;

   task automatic step();
      @(negedge clk);
      ncyc++;
      if (bus.wheel_tick === 1'b1) begin
         ticks++;
         last_tick = ncyc;
      end
   endtask

   task automatic wait_state(input logic [1:0] s, input int lim,
                             input string nm);
      int i = 0;
      while (bus.state !== s && i < lim) begin
         step();
         i++;
      end
      chk(nm, 32'(bus.state === s), 1);
   endtask

   task automatic wait_wtick(input int lim, input string nm);
      int i = 0;
      do begin
         step();
         i++;
      end while (bus.wait_tick !== 1'b1 && i < lim);
      chk(nm, 32'(bus.wait_tick === 1'b1), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int lat_ok, t0, k0, c0;
      bus.start_key  = 1'b0;
      bus.end_key    = 1'b0;
      bus.pulse_port = 1'b0;
      repeat (3) step();
      chk("reset_outputs", 32'(act_v), 0);
      rst_n = 1'b1;
      repeat (2) step();

      // 1: trip start
      bus.start_key = 1'b1;
      step();
      bus.start_key = 1'b0;
      chk("t1_state", 32'(bus.state), 1);
      chk("t1_meter_clr", 32'(bus.meter_clr), 1);
      chk("t1_dist_en", 32'(bus.dist_en), 1);
      chk("t1_seg_en", 32'(bus.seg_en), 1);
      chk("t1_wait_min", 32'(bus.wait_min), 0);
      step();
      chk("t1_clr_one_cycle", 32'(bus.meter_clr), 0);

      // 2: ten wheel rises; tick seen on the 4th falling edge
      // after the pulse is raised (3 rising edges after sampling)
      lat_ok = 0;
      k0 = ticks;
      for (int r = 0; r < 10; r++) begin
         bus.pulse_port = 1'b1;
         for (int c = 0; c < 40; c++) begin
            step();
            if (bus.wheel_tick === 1'b1 && c == 3) lat_ok++;
         end
         bus.pulse_port = 1'b0;
         repeat (40) step();
      end
      chk("t2_tick_count", 32'(ticks - k0), 10);
      chk("t2_tick_latency", 32'(lat_ok), 10);

      // 3: stop -> WAIT, then two billable wait units
      wait_state(2'b10, 300, "t3_enter_wait");
      chk("t3_wait_delay", 32'(ncyc - last_tick), 100);
      chk("t3_stat_led", 32'(bus.stat_led), 1);
      t0 = ncyc;
      wait_wtick(400, "t3_tick1_seen");
      chk("t3_tick1_delay", 32'(ncyc - t0), 150);
      chk("t3_wait_min1", 32'(bus.wait_min), 1);
      t0 = ncyc;
      wait_wtick(400, "t3_tick2_seen");
      chk("t3_tick2_delay", 32'(ncyc - t0), 150);
      chk("t3_wait_min2", 32'(bus.wait_min), 2);

      // 4: two seconds of waiting, resume, stop again
      repeat (96) step();
      bus.pulse_port = 1'b1;
      repeat (4) step();
      chk("t4_back_to_run", 32'(bus.state), 1);
      chk("t4_first_tick", 32'(bus.wheel_tick), 1);
      repeat (36) step();
      bus.pulse_port = 1'b0;
      repeat (40) step();
      bus.pulse_port = 1'b1;
      repeat (40) step();
      bus.pulse_port = 1'b0;
      wait_state(2'b10, 300, "t4_enter_wait");
      t0 = ncyc;
      wait_wtick(400, "t4_tick_seen");
      chk("t4_retained_delay", 32'(ncyc - t0), 50);
      chk("t4_wait_min3", 32'(bus.wait_min), 3);

      // 5: end_key and a wheel edge in the same cycle
      bus.pulse_port = 1'b1;
      repeat (3) step();
      bus.end_key = 1'b1;
      k0 = ticks;
      step();
      bus.end_key = 1'b0;
      chk("t5_state_end", 32'(bus.state), 3);
      chk("t5_fare_hold", 32'(bus.fare_hold), 1);
      chk("t5_no_tick", 32'(bus.wheel_tick), 0);
      chk("t5_stat_led", 32'(bus.stat_led), 0);
      chk("t5_wmin_hold", 32'(bus.wait_min), 3);
      repeat (10) step();
      bus.pulse_port = 1'b0;
      repeat (10) step();
      bus.pulse_port = 1'b1;
      repeat (20) step();
      bus.pulse_port = 1'b0;
      chk("t5_end_masks_wheel", 32'(ticks - k0), 0);
      bus.start_key = 1'b1;
      bus.end_key   = 1'b1;
      step();
      bus.start_key = 1'b0;
      bus.end_key   = 1'b0;
      chk("t5_end_wins", 32'(bus.state), 0);
      chk("t5_seg_off", 32'(bus.seg_en), 0);
      repeat (3) step();

      // 6: async reset in the middle of WAIT
      bus.start_key = 1'b1;
      step();
      bus.start_key = 1'b0;
      chk("t6_new_trip_wmin", 32'(bus.wait_min), 0);
      wait_state(2'b10, 300, "t6_enter_wait");
      repeat (20) step();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("t6_async_clear", 32'(act_v), 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      c0 = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.meter_clr !== 1'b0 || bus.state !== 2'b00) c0++;
      end
      chk("t6_idle_no_clr", 32'(c0), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
